// File: rtl/tdp_ram_portb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : tdp_ram_portb_scheduler_if
// Brief   : Requester, clear-control and RAM port B bundle of the scheduler.
// Revision: 1.0
// ============================================================================
interface tdp_ram_portb_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 9
);
    logic                  clear_req;
    logic                  clear_busy;

    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_W-1:0]     req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_W-1:0]     req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // System side: requesters plus the RAM model.
    modport master (
        output clear_req,
        input  clear_busy,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    // Scheduler side.
    modport slave (
        input  clear_req,
        output clear_busy,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/tdp_ram_portb_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tdp_ram_portb_scheduler
// Brief   : Round-robin port B arbiter for two requesters with full-RAM clear.
// Revision: 1.0
// ============================================================================
module tdp_ram_portb_scheduler #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 512,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  wire                         clk,
    input  wire                         rst_n,
    tdp_ram_portb_scheduler_if.slave    bus
);
    localparam int                ADDR_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     w_cnt_next;
    logic                  r_last_grant;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_clear_busy;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [ADDR_W-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            if (w_grant0 || w_grant1) begin
                r_last_grant <= w_grant1;
            end
            r_rsp0_valid <= w_grant0 && !bus.req0_we;
            r_rsp1_valid <= w_grant1 && !bus.req1_we;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_clear_busy = 1'b1;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = '0;
        w_ram_wdata  = '0;
        case (r_state)
            ST_INIT: begin
                w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_cnt;
                w_ram_wdata = CLEAR_VALUE;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_next = ST_SERVE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            ST_SERVE: begin
                w_clear_busy = 1'b0;
                // On a tie the requester that did not win last time goes first.
                if (bus.req0_valid && bus.req1_valid) begin
                    w_grant0 = r_last_grant;
                    w_grant1 = !r_last_grant;
                end else begin
                    w_grant0 = bus.req0_valid;
                    w_grant1 = bus.req1_valid;
                end
                if (w_grant0) begin
                    w_ram_en    = 1'b1;
                    w_ram_we    = bus.req0_we;
                    w_ram_addr  = bus.req0_addr;
                    w_ram_wdata = bus.req0_wdata;
                end else if (w_grant1) begin
                    w_ram_en    = 1'b1;
                    w_ram_we    = bus.req1_we;
                    w_ram_addr  = bus.req1_addr;
                    w_ram_wdata = bus.req1_wdata;
                end
                if (bus.clear_req) begin
                    w_state_next = ST_CLEAR;
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    assign bus.clear_busy = w_clear_busy;
    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.ram_en     = w_ram_en;
    assign bus.ram_we     = w_ram_we;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_wdata  = w_ram_wdata;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = r_rsp0_valid ? bus.ram_rdata : '0;
    assign bus.rsp1_rdata = r_rsp1_valid ? bus.ram_rdata : '0;

endmodule
`default_nettype wire
